// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC sample feeder.
// Holds the sample/FIFO/divider widths, the playback state enum and the reset value for dac_data.
package dac_pkg;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 8;
  localparam int DIV_WIDTH = 16;
  localparam int LVL_W     = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    UNDER = 2'd2
  } state_t;

  // Reset and idle value of the DAC input: mid-range code.
  function automatic logic [WIDTH-1:0] midscale();
    return {1'b1, {(WIDTH-1){1'b0}}};
  endfunction
endpackage

// File: rtl/dac_feeder_if.sv
// Producer handshake, playback control and DAC-side outputs of dac_feeder.
// The master modport is the controlling side; the slave modport is the feeder.
interface dac_feeder_if;
  logic [dac_pkg::WIDTH-1:0]     s_data;
  logic                          s_valid;
  logic                          s_ready;
  logic                          enable;
  logic [dac_pkg::DIV_WIDTH-1:0] period;
  logic                          underrun_clr;
  logic [dac_pkg::WIDTH-1:0]     dac_data;
  logic                          strobe;
  logic                          underrun;
  logic [dac_pkg::LVL_W-1:0]     level;

  modport master (
    output s_data, s_valid, enable, period, underrun_clr,
    input  s_ready, dac_data, strobe, underrun, level
  );

  modport slave (
    input  s_data, s_valid, enable, period, underrun_clr,
    output s_ready, dac_data, strobe, underrun, level
  );
endinterface

// File: rtl/dac_fifo.sv
// Sample FIFO: power-of-two depth, wrapping pointers, explicit occupancy count.
// Push is ignored when full and pop when empty, so callers may request either freely.
module dac_fifo #(
  parameter int W = 8,
  parameter int D = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [W-1:0]          din_i,
  input  logic                  pop_i,
  output logic [W-1:0]          dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [$clog2(D):0]    level_o
);
  localparam int PW = $clog2(D);

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == (PW+1)'(D));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];
  assign level_o = level_q;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    if (do_push && !do_pop)      level_d = level_q + (PW+1)'(1);
    else if (do_pop && !do_push) level_d = level_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/dac_feeder.sv
// Buffers producer samples and plays them to a DAC at a programmable sample period.
// A free-running tick counter paces pops from the FIFO into the registered dac_data output.
//
// state | meaning
// IDLE  | playback stopped, counter cleared, dac_data held
// RUN   | playing; last tick found a sample
// UNDER | playing; last tick found the FIFO empty
module dac_feeder
  import dac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  dac_feeder_if.slave bus
);
  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     dac_q, dac_d;
  logic                 strobe_q, strobe_d;
  logic                 underrun_q, underrun_d;

  logic [WIDTH-1:0]     fifo_head;
  logic                 fifo_full, fifo_empty;
  logic                 tick, pop;

  dac_fifo #(.W(WIDTH), .D(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.s_valid),
    .din_i   (bus.s_data),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (bus.level)
  );

  // The enable cycle itself can tick, giving period+1 cycles to the first sample.
  assign tick = bus.enable && (cnt_q == bus.period);
  assign pop  = tick && !fifo_empty;

  assign bus.s_ready  = !fifo_full;
  assign bus.dac_data = dac_q;
  assign bus.strobe   = strobe_q;
  assign bus.underrun = underrun_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + DIV_WIDTH'(1);
    dac_d      = pop ? fifo_head : dac_q;
    strobe_d   = pop;
    underrun_d = underrun_q;

    if (tick && fifo_empty)    underrun_d = 1'b1;
    else if (bus.underrun_clr) underrun_d = 1'b0;

    if (!bus.enable || tick) cnt_d = '0;

    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = (tick && fifo_empty) ? UNDER : RUN;
        RUN:     if (tick && fifo_empty) state_d = UNDER;
        UNDER:   if (pop) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dac_q      <= midscale();
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dac_q      <= dac_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end
endmodule

// File: doc/dac_feeder.md
DAC_FEEDER -- requirements
Module: dac_feeder

Interface
REQ-001 WIDTH, 8, sample width; matches the downstream sigma-delta dac data width.
REQ-002 DEPTH, 8, FIFO entries; power of two, at least 2.
REQ-003 DIV_WIDTH, 16, sample-period counter width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_data  input  WIDTH  sample from producer.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_ready  output  1  FIFO can accept a sample.
REQ-009 enable  input  1  run sample playback.
REQ-010 period  input  DIV_WIDTH  sample interval minus one, in clk cycles.
REQ-011 underrun_clr  input  1  clears sticky underrun.
REQ-012 dac_data  output  WIDTH  registered sample to the dac data input.
REQ-013 strobe  output  1  one-cycle pulse when dac_data takes a new sample.
REQ-014 underrun  output  1  sticky flag: a sample tick found the FIFO empty.
REQ-015 level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Function
REQ-016 Push: s_valid && s_ready writes s_data at the FIFO tail on that edge.
REQ-017 s_ready = (level != DEPTH); a pop in the same cycle does not raise s_ready while full.
REQ-018 Push and pop in the same cycle (not full, not empty): level is unchanged and both operations take effect.
REQ-019 Pointers wrap modulo DEPTH; level never exceeds DEPTH or drops below 0.
REQ-020 Tick counter cnt: while enable=1, cnt increments each cycle; tick when cnt == period, then cnt returns to 0 on the next edge.
REQ-021 period=0: tick every cycle.
REQ-022 A change of period takes effect at the next compare; if cnt > period, cnt wraps naturally at 2^DIV_WIDTH-1 back to 0. No early tick.
REQ-023 States: IDLE, RUN, UNDER.
REQ-024 IDLE: enable=0, cnt held at 0, no ticks, dac_data held. IDLE->RUN when enable=1.
REQ-025 RUN: on tick with level>0, pop head into dac_data on that edge; strobe=1 in the following cycle (registered with dac_data).
REQ-026 RUN: on tick with level=0, dac_data holds, strobe stays 0, underrun is set, and the state goes to UNDER.
REQ-027 UNDER: on tick with level>0, pop as in RUN and go to RUN; on tick with level=0, stay in UNDER.
REQ-028 Empty-at-tick is judged on pre-edge level; a push in the same cycle is not popped until the next tick.
REQ-029 enable=0 in any state: go to IDLE next edge, cnt goes to 0, and the FIFO contents are retained.
REQ-030 Underrun is cleared by underrun_clr; a new underrun event in the same cycle wins (flag stays 1).
REQ-031 Output latency: dac_data changes on the same edge as the tick cycle ends; first sample appears period+1 cycles after enable rises (FIFO non-empty).

Reset
REQ-032 rst=1 asynchronously forces:
- state to IDLE.
- cnt, pointers and level to 0.
- dac_data to midscale (1 << (WIDTH-1)).
- strobe to 0.
- underrun to 0.
- s_ready to 1 after release.
REQ-033 Reset mid-operation discards FIFO contents; no strobe occurs in the cycle after release.

Structure
REQ-034 Shared package dac_pkg holds the state enum (IDLE, RUN, UNDER) and the midscale constant function.
REQ-035 The FIFO is a sub-module dac_fifo (storage, pointers, level, full/empty). Tick counter and FSM stay in dac_feeder.

Verification
REQ-036 Reset: rst pulse -> dac_data=0x80, strobe=0, underrun=0, level=0, s_ready=1.
REQ-037 Playback: push 0x10,0x20,0x30; period=3; enable=1 -> dac_data 0x10,0x20,0x30 at 4-cycle spacing, one strobe each, first strobe 4 cycles after enable.
REQ-038 Full: push 9 samples with no enable, DEPTH=8 -> s_ready=0 after the 8th, the 9th is not accepted, level=8.
REQ-039 Underrun: push 1 sample, period=0, enable -> dac_data takes the sample, then holds; underrun=1 on the next tick and the state is UNDER. Pushing 0x55 gives dac_data=0x55, state RUN, underrun still 1 until underrun_clr.
REQ-040 Simultaneous: underrun_clr asserted in an empty-tick cycle -> underrun stays 1. A push in a tick cycle while empty -> underrun is set, and the sample is popped on the following tick.
REQ-041 Mid-run: deassert enable -> IDLE, dac_data held, level retained. Assert rst while level=5 -> level=0, dac_data=0x80.
